// File: rtl/lifo_fifo_pkg.sv
// Shared types for the multi-mode LIFO/FIFO/buffer storage block.
package lifo_fifo_pkg;

  typedef enum logic [1:0] {
    MODE_LIFO   = 2'd0,
    MODE_FIFO   = 2'd1,
    MODE_BUFFER = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

endpackage

// File: rtl/lifo_fifo_mem.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
module lifo_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                       i_clk,
  input  logic                       i_wr_en,
  input  logic [$clog2(DEPTH)-1:0]   i_wr_addr,
  input  logic [DATA_W-1:0]          i_wr_data,
  input  logic [$clog2(DEPTH)-1:0]   i_rd_addr,
  output logic [DATA_W-1:0]          o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/lifo_fifo_queue.sv
// Multi-mode storage controller: LIFO stack, FIFO queue or registered pass-through,
// selected at run time; a mode change flushes the storage.
module lifo_fifo_queue
  import lifo_fifo_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [1:0]                   i_mode,
  input  logic                         i_chip_en,
  input  logic                         i_clear,
  input  logic [DATA_W-1:0]            i_din,
  input  logic                         i_push,
  input  logic                         i_pop,
  output logic [DATA_W-1:0]            o_dout,
  output logic                         o_dout_valid,
  output logic                         o_empty,
  output logic                         o_full,
  output logic                         o_almost_empty,
  output logic                         o_almost_full,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_overflow,
  output logic                         o_underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  mode_e             r_mode_q;
  logic [CW-1:0]     r_count;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_valid;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_empty;
  logic              w_full;
  logic              w_clear;
  logic              w_mode_chg;
  logic              w_run;
  logic              w_storage;
  logic              w_buf;
  logic              w_push_req;
  logic              w_pop_req;
  logic              w_push_ok;
  logic              w_pop_ok;
  logic              w_push_err;
  logic              w_pop_err;
  logic [CW-1:0]     w_count_nxt;
  logic [PW-1:0]     w_top_idx;
  logic [PW-1:0]     w_wr_addr;
  logic [PW-1:0]     w_rd_addr;
  logic [DATA_W-1:0] w_rd_data;

  function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

  // Reserved mode ignores clear, but a mode change out of it must still work.
  assign w_clear    = i_chip_en && i_clear && (r_mode_q != MODE_RSVD);
  assign w_mode_chg = i_chip_en && !w_clear && (i_mode != r_mode_q);
  assign w_run      = i_chip_en && !w_clear && !w_mode_chg;
  assign w_storage  = (r_mode_q == MODE_LIFO) || (r_mode_q == MODE_FIFO);
  assign w_buf      = w_run && (r_mode_q == MODE_BUFFER);

  assign w_push_req = w_run && w_storage && i_push;
  assign w_pop_req  = w_run && w_storage && i_pop;
  assign w_pop_ok   = w_pop_req && !w_empty;
  assign w_push_ok  = w_push_req && (!w_full || w_pop_ok);
  assign w_pop_err  = w_pop_req && !w_pop_ok;
  assign w_push_err = w_push_req && !w_push_ok;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push_ok && !w_pop_ok)      w_count_nxt = r_count + CW'(1);
    else if (w_pop_ok && !w_push_ok) w_count_nxt = r_count - CW'(1);
  end

  // In LIFO mode a simultaneous push/pop overwrites the entry just read out.
  assign w_top_idx = PW'(r_count - CW'(1));

  always_comb begin
    w_wr_addr = r_wr_ptr;
    w_rd_addr = r_rd_ptr;
    if (r_mode_q == MODE_LIFO) begin
      w_rd_addr = w_top_idx;
      w_wr_addr = w_pop_ok ? w_top_idx : PW'(r_count);
    end
  end

  lifo_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .i_clk     (i_clk),
    .i_wr_en   (w_push_ok),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (i_din),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode_q     <= MODE_LIFO;
      r_count      <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_dout_valid <= w_pop_ok || w_buf;
      if (w_clear) begin
        r_count     <= '0;
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end else if (w_mode_chg) begin
        r_count  <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_mode_q <= mode_e'(i_mode);
      end else if (w_run) begin
        r_count <= w_count_nxt;
        if (w_pop_ok)   r_dout      <= w_rd_data;
        if (w_buf)      r_dout      <= i_din;
        if (w_push_err) r_overflow  <= 1'b1;
        if (w_pop_err)  r_underflow <= 1'b1;
        if (r_mode_q == MODE_FIFO) begin
          if (w_push_ok) r_wr_ptr <= f_ptr_inc(r_wr_ptr);
          if (w_pop_ok)  r_rd_ptr <= f_ptr_inc(r_rd_ptr);
        end
      end
    end
  end

  assign o_dout         = r_dout;
  assign o_dout_valid   = r_dout_valid;
  assign o_count        = r_count;
  assign o_empty        = w_empty;
  assign o_full         = w_full;
  assign o_almost_empty = (r_count <= CW'(AE_LEVEL));
  assign o_almost_full  = (r_count >= CW'(AF_LEVEL));
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_lifo_fifo_queue.sv
// Directed bench for lifo_fifo_queue with DEPTH=4, AF_LEVEL=3, AE_LEVEL=1.
module tb_lifo_fifo_queue;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        mode;
  logic              chip_en;
  logic              clear;
  logic [DATA_W-1:0] din;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              empty;
  logic              full;
  logic              almost_empty;
  logic              almost_full;
  logic [2:0]        count;
  logic              overflow;
  logic              underflow;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lifo_fifo_queue #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .AF_LEVEL (3),
    .AE_LEVEL (1)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_mode         (mode),
    .i_chip_en      (chip_en),
    .i_clear        (clear),
    .i_din          (din),
    .i_push         (push),
    .i_pop          (pop),
    .o_dout         (dout),
    .o_dout_valid   (dout_valid),
    .o_empty        (empty),
    .o_full         (full),
    .o_almost_empty (almost_empty),
    .o_almost_full  (almost_full),
    .o_count        (count),
    .o_overflow     (overflow),
    .o_underflow    (underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Called at a negedge; applies inputs for one rising edge and returns at the next negedge.
  task automatic step(input logic p_push, input logic p_pop, input logic [7:0] p_din,
                      input logic p_clr = 1'b0);
    push  = p_push;
    pop   = p_pop;
    din   = p_din;
    clear = p_clr;
    @(posedge clk);
    @(negedge clk);
    push  = 1'b0;
    pop   = 1'b0;
    clear = 1'b0;
  endtask

  task automatic set_mode(input logic [1:0] m);
    mode = m;
    step(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    logic [7:0] seq_a [3];
    logic [7:0] seq_b [4];
    seq_a = '{8'h03, 8'h04, 8'h01};
    seq_b = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};

    rst_n = 1'b0; mode = 2'd0; chip_en = 1'b1; clear = 1'b0;
    din = '0; push = 1'b0; pop = 1'b0;
    #12;
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // LIFO order
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, seq_a[i]);
    chk("lifo_count3", count, 3);
    step(1'b0, 1'b1, 8'h00); chk("lifo_pop0", dout, 8'h01); chk("lifo_valid", dout_valid, 1);
    step(1'b0, 1'b1, 8'h00); chk("lifo_pop1", dout, 8'h04);
    step(1'b0, 1'b1, 8'h00); chk("lifo_pop2", dout, 8'h03);
    chk("lifo_count0", count, 0);
    chk("lifo_empty", empty, 1);
    chk("lifo_unf", underflow, 0);
    step(1'b0, 1'b0, 8'h00); chk("lifo_valid_drop", dout_valid, 0);

    // FIFO order and pointer wrap
    set_mode(2'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, seq_a[i]);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'h00);
      chk("fifo_pop", dout, seq_a[i]);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, seq_b[i]);
    chk("fifo_wrap_full", full, 1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 8'h00);
      chk("fifo_wrap_pop", dout, seq_b[i]);
    end
    chk("fifo_wrap_empty", empty, 1);

    // LIFO full/empty boundaries
    set_mode(2'd0);
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 1'b0, 8'(i));
      if (i == 3) begin
        chk("b_af3", almost_full, 1);
        chk("b_full3", full, 0);
      end
      if (i == 4) begin
        chk("b_full4", full, 1);
        chk("b_ovf4", overflow, 0);
      end
    end
    chk("b_ovf", overflow, 1);
    chk("b_count4", count, 4);
    for (int i = 4; i >= 1; i--) begin
      step(1'b0, 1'b1, 8'h00);
      chk("b_pop", dout, 32'(i));
    end
    chk("b_ae", almost_empty, 1);
    chk("b_unf_before", underflow, 0);
    step(1'b0, 1'b1, 8'h00);
    chk("b_unf", underflow, 1);
    chk("b_empty", empty, 1);
    chk("b_valid_rej", dout_valid, 0);
    chk("b_dout_hold", dout, 8'h01);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("clr_ovf", overflow, 0);
    chk("clr_unf", underflow, 0);

    // Simultaneous push+pop
    set_mode(2'd1);
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 8'(i));
    step(1'b1, 1'b1, 8'h55);
    chk("pp_fifo_dout", dout, 8'h01);
    chk("pp_fifo_count", count, 4);
    chk("pp_fifo_ovf", overflow, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    chk("pp_fifo_last", dout, 8'h55);
    set_mode(2'd0);
    step(1'b1, 1'b0, 8'h01);
    step(1'b1, 1'b0, 8'h02);
    step(1'b1, 1'b1, 8'h66);
    chk("pp_lifo_dout", dout, 8'h02);
    chk("pp_lifo_count", count, 2);
    step(1'b0, 1'b1, 8'h00); chk("pp_lifo_top", dout, 8'h66);
    step(1'b0, 1'b1, 8'h00); chk("pp_lifo_bot", dout, 8'h01);

    // BUFFER pass-through
    set_mode(2'd2);
    step(1'b0, 1'b0, 8'h05); chk("buf_d0", dout, 8'h05); chk("buf_v0", dout_valid, 1);
    step(1'b1, 1'b1, 8'h02); chk("buf_d1", dout, 8'h02);
    chk("buf_count", count, 0);
    chk("buf_ovf", overflow, 0);
    chk("buf_unf", underflow, 0);
    step(1'b0, 1'b0, 8'h00); chk("buf_d2", dout, 8'h00); chk("buf_v2", dout_valid, 1);

    // Disruptions
    mode = 2'd1;
    step(1'b1, 1'b0, 8'h77);
    chk("mchg_push_ign", count, 0);
    step(1'b1, 1'b0, 8'h07);
    step(1'b1, 1'b0, 8'h08);
    step(1'b1, 1'b0, 8'h09);
    step(1'b0, 1'b1, 8'h00);
    chk("dis_pop", dout, 8'h07);
    chk("dis_count", count, 2);
    chip_en = 1'b0;
    step(1'b0, 1'b1, 8'h00);
    chk("ce_dout", dout, 8'h07);
    chk("ce_valid", dout_valid, 0);
    chk("ce_count", count, 2);
    chip_en = 1'b1;
    set_mode(2'd0);
    chk("mchg_count", count, 0);
    chk("mchg_empty", empty, 1);
    step(1'b1, 1'b0, 8'h21);
    step(1'b1, 1'b0, 8'h22);
    step(1'b0, 1'b1, 8'h00); chk("pre_rst_pop", dout, 8'h22);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00); chk("pre_rst_unf", underflow, 1);
    push = 1'b1; din = 8'h33;
    @(posedge clk);
    #2;
    chk("pre_rst_count", count, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_dout", dout, 0);
    chk("arst_empty", empty, 1);
    chk("arst_ae", almost_empty, 1);
    chk("arst_unf", underflow, 0);
    push = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lifo_fifo_queue.md
# lifo_fifo_queue

Parametrised multi-mode storage block: one memory serving as a LIFO stack, a FIFO queue, or a registered pass-through buffer, selected at run time. It is the generalised successor of the fixed 8-bit LIFO/FIFO/buffer unit. It adds the following:
- Configurable data width and depth.
- A single chip enable.
- Simultaneous push/pop.
- Occupancy count, almost-full/almost-empty flags, and sticky overflow/underflow error flags.

It sits between a producer and a consumer on the same clock.

## Interface
- DATA_W, 8, data width in bits (≥1)
- DEPTH, 16, number of entries (≥2, any integer, not necessarily a power of two)
- AF_LEVEL, DEPTH-2, almost_full asserted when count ≥ AF_LEVEL
- AE_LEVEL, 2, almost_empty asserted when count ≤ AE_LEVEL

- CLK  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; asserting it (0) clears all state immediately
- mode  in  2  0 LIFO, 1 FIFO, 2 BUFFER, 3 reserved
- chip_en  in  1  block enable
- clear  in  1  synchronous flush
- din  in  DATA_W  write data
- push  in  1  write request
- pop  in  1  read request
- dout  out  DATA_W  registered read data
- dout_valid  out  1  dout updated this cycle
- empty, full  out  1  count==0 / count==DEPTH
- almost_empty, almost_full  out  1  threshold flags
- count  out  $clog2(DEPTH+1)  occupancy
- overflow, underflow  out  1  sticky error flags

## Operation
- **Reset values:** dout=0, dout_valid=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, pointers=0, mode_q=0.
- **chip_en=0:** all state is held, dout is held, dout_valid=0, and push/pop/clear are ignored.
- **Priority when enabled:** clear > mode change > push/pop.
  - clear flushes the storage (count and pointers go to 0) and clears overflow/underflow.
  - Mode change occurs when `mode` ≠ registered `mode_q`. It flushes the storage, loads `mode_q`, and ignores push/pop for that cycle. Sticky flags are kept.
- **Acceptance rules:**
  - pop is accepted iff pop && !empty. Otherwise pop sets underflow.
  - push is accepted iff push && (!full || pop accepted). Otherwise push sets overflow.
- **FIFO:**
  - Write at wr_ptr, read at rd_ptr.
  - Each pointer wraps from DEPTH-1 to 0.
  - Push and pop together: both are performed and count is unchanged.
- **LIFO:**
  - Push writes at top and increments count.
  - Pop returns entry[count-1] and decrements count.
  - Push and pop together on non-empty: dout = old top, din replaces top, count unchanged.
- **Empty with push+pop:** the pop is rejected (underflow=1), the push is accepted, and there is no bypass.
- **BUFFER:**
  - dout ← din every enabled cycle, dout_valid=1.
  - push/pop are ignored and storage is untouched (always empty after the mode-change flush).
- **Reserved mode (3):** behaves as chip_en=0 after the flush.
- **Count:** count arithmetic never wraps; it saturates by construction through the acceptance rules.

## Timing
- An accepted pop updates dout at the same edge. dout_valid=1 for exactly that one cycle.
- Flags derive from the count register and reflect the post-edge state. Push→full and pop→empty are visible one cycle after the request is sampled.
- Sticky flags set on the edge of the failed request and clear only on clear or reset.
- Async reset takes effect mid-operation without waiting for an edge. Deassertion is synchronised externally.

## Structure
- Package `lifo_fifo_pkg`: mode typedef enum (MODE_LIFO=0, MODE_FIFO=1, MODE_BUFFER=2, MODE_RSVD=3).
- Sub-module `lifo_fifo_mem`: DEPTH×DATA_W array with synchronous write and asynchronous read, one write port and one read port.
- Top level contains the control logic, pointers, counter and flags.

## Test plan
All scenarios use DATA_W=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1.

1. **LIFO:** push 0x03, 0x04, 0x01, then pop ×3 → dout 0x01, 0x04, 0x03; count 3→0; empty=1; underflow=0.
2. **FIFO wrap:**
   - push 0x03, 0x04, 0x01, then pop ×3 → 0x03, 0x04, 0x01.
   - Then push 0x0A..0x0D and pop ×4 → 0x0A..0x0D. Pointers wrap with no data loss.
3. **LIFO full/empty:**
   - push 1..6 → full=1 after 4th push, almost_full=1 at count 3, overflow=1, count=4.
   - pop ×5 → 4, 3, 2, 1, then underflow=1, empty=1.
4. **Simultaneous push+pop:**
   - FIFO at full (1, 2, 3, 4): push 0x55 with pop → dout=1, count stays 4, overflow=0.
   - LIFO with 1, 2: push 0x66 with pop → dout=2, top=0x66.
5. **BUFFER:** din 0x05, 0x02, 0x00 → dout 0x05, 0x02, 0x00 one edge after each, with dout_valid=1; push/pop ignored.
6. **Disruptions:**
   - chip_en=0 during pops holds dout and count.
   - Mode switch FIFO→LIFO with count=2 → count=0, empty=1.
   - reset=0 mid-push clears all outputs to their reset values asynchronously.
